// File: rtl/mccoy_pkg.sv
// rtl/mccoy_pkg.sv - shared constants and state type for the McCoy program driver
package mccoy_pkg;
  localparam int INSTR_W = 6;
  localparam int OUT_W   = 8;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mccoy_prog_buf.sv
// rtl/mccoy_prog_buf.sv - program storage, synchronous write, combinational read
module mccoy_prog_buf
  import mccoy_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mccoy_prog_driver.sv
// rtl/mccoy_prog_driver.sv - loads a short program and replays it onto the core instruction bus
module mccoy_prog_driver
  import mccoy_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int HOLD   = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic               abort,
  input  logic               clear,
  output logic [INSTR_W-1:0] instr,
  input  logic [OUT_W-1:0]   cpu_out,
  output logic [OUT_W-1:0]   result,
  output logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    prog_len
);
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W:0]    idx_q, idx_d, len_q, len_d, nxt_idx;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [INSTR_W-1:0] instr_q, instr_d, rdata;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               rv_q, rv_d, wr_fire;

  assign nxt_idx  = idx_q + (ADDR_W+1)'(1);
  assign wr_ready = reset && (state_q == IDLE) && (len_q < (ADDR_W+1)'(DEPTH)) && !start && !clear;
  assign wr_fire  = wr_valid && wr_ready;

  // In IDLE the read port looks at entry 0 so start can load it; in RUN it looks one ahead.
  mccoy_prog_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk_i   (clk),
    .we_i    (wr_fire),
    .waddr_i (len_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .raddr_i ((state_q == RUN) ? nxt_idx[ADDR_W-1:0] : '0),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hc_d     = hc_q;
    len_d    = len_q;
    instr_d  = instr_q;
    result_d = result_q;
    rv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_d = NOP;
        if (start) begin
          idx_d = '0;
          hc_d  = '0;
          if (len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            instr_d = rdata;
          end
        end else if (clear) begin
          len_d = '0;
        end else if (wr_fire) begin
          len_d = len_q + (ADDR_W+1)'(1);
        end
      end
      RUN: begin
        if (hc_q == HC_W'(HOLD - 1)) begin
          result_d = cpu_out;
          rv_d     = 1'b1;
          hc_d     = '0;
          if (idx_q == len_q - (ADDR_W+1)'(1)) begin
            state_d = DONE;
            instr_d = NOP;
          end else begin
            idx_d   = nxt_idx;
            instr_d = rdata;
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
        // Abort still lets a coinciding end-of-step sample through.
        if (abort) begin
          state_d = DONE;
          instr_d = NOP;
        end
      end
      DONE: begin
        state_d = IDLE;
        instr_d = NOP;
      end
      default: begin
        state_d = IDLE;
        instr_d = NOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      hc_q     <= '0;
      len_q    <= '0;
      instr_q  <= NOP;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hc_q     <= hc_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign instr        = instr_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign prog_len     = len_q;
endmodule

// File: tb/tb_mccoy_prog_driver.sv
// tb/tb_mccoy_prog_driver.sv - scoreboard bench for mccoy_prog_driver at HOLD=1 and HOLD=3
module tb_mccoy_prog_driver;
  logic       clk = 1'b0;
  logic       reset, wr_valid, start, abort, clear;
  logic [5:0] wr_data;
  logic [5:0] instr1, instr3;
  logic [7:0] cpu1, cpu3, res1, res3;
  logic       rv1, rv3, busy1, busy3, done1, done3, wrr1, wrr3;
  logic [4:0] len1, len3;

  int         n_err = 0;
  int         n_chk = 0;
  int         rv3_cnt = 0;
  bit         mon1_en = 0;
  bit         mon3_en = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [5:0] prog3[4] = '{6'h2A, 6'h15, 6'h3C, 6'h07};

  always #5 clk = ~clk;

  // Stand-in for the core: output is a fixed function of the presented instruction.
  function automatic logic [7:0] core_f(input logic [5:0] x);
    return {x[1:0], x} ^ 8'hA5;
  endfunction

  assign cpu1 = core_f(instr1);
  assign cpu3 = core_f(instr3);

  mccoy_prog_driver #(.DEPTH(16), .HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wrr1),
    .start(start), .abort(abort), .clear(clear), .instr(instr1), .cpu_out(cpu1),
    .result(res1), .result_valid(rv1), .busy(busy1), .done(done1), .prog_len(len1)
  );

  mccoy_prog_driver #(.DEPTH(16), .HOLD(3)) dut3 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wrr3),
    .start(start), .abort(abort), .clear(clear), .instr(instr3), .cpu_out(cpu3),
    .result(res3), .result_valid(rv3), .busy(busy3), .done(done3), .prog_len(len3)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] d, input logic exp_rdy);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    chk_eq("wr_ready", 32'(wrr1), 32'(exp_rdy));
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel3, input int exp_cyc, input string tag);
    int cyc = 1;
    while (!(sel3 ? done3 : done1) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_eq(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  always @(negedge clk) begin
    if (mon1_en && rv1) begin
      if (q1.size() == 0) chk_eq("rv1_unexpected", 32'(rv1), 32'd0);
      else                chk_eq("result1", 32'(res1), 32'(q1.pop_front()));
    end
    if (mon3_en && rv3) begin
      rv3_cnt++;
      if (q3.size() == 0) chk_eq("rv3_unexpected", 32'(rv3), 32'd0);
      else                chk_eq("result3", 32'(res3), 32'(q3.pop_front()));
    end
  end

  initial begin
    reset = 1'b0; wr_valid = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0; wr_data = '0;
    tick(); tick();
    chk_eq("rst_instr", 32'(instr1), 32'd0);
    chk_eq("rst_len", 32'(len1), 32'd0);
    chk_eq("rst_busy", 32'(busy1), 32'd0);
    chk_eq("rst_done", 32'(done1), 32'd0);
    chk_eq("rst_result", 32'(res1), 32'd0);
    chk_eq("rst_rv", 32'(rv1), 32'd0);
    chk_eq("rst_wr_ready", 32'(wrr1), 32'd0);
    reset = 1'b1;
    mon1_en = 1'b1;

    // load three and replay at HOLD=1
    wr(6'h19, 1'b1); wr(6'h03, 1'b1); wr(6'h24, 1'b1);
    chk_eq("len3", 32'(len1), 32'd3);
    q1.push_back(core_f(6'h19)); q1.push_back(core_f(6'h03)); q1.push_back(core_f(6'h24));
    start = 1'b1;
    @(negedge clk);
    chk_eq("ready_start", 32'(wrr1), 32'd0);
    tick(); start = 1'b0;
    chk_eq("instr_c1", 32'(instr1), 32'h19);
    chk_eq("busy_c1", 32'(busy1), 32'd1);
    tick(); chk_eq("instr_c2", 32'(instr1), 32'h03);
    tick(); chk_eq("instr_c3", 32'(instr1), 32'h24);
    tick();
    chk_eq("done_c4", 32'(done1), 32'd1);
    chk_eq("instr_c4", 32'(instr1), 32'd0);
    chk_eq("busy_c4", 32'(busy1), 32'd0);
    tick();
    chk_eq("done_c5", 32'(done1), 32'd0);
    chk_eq("result_last", 32'(res1), 32'(core_f(6'h24)));

    // full buffer, then start with a simultaneous write
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 17; i++) wr(6'(i + 1), (i < 16));
    chk_eq("len_full", 32'(len1), 32'd16);
    for (int i = 0; i < 16; i++) q1.push_back(core_f(6'(i + 1)));
    wr_valid = 1'b1; wr_data = 6'h3F; start = 1'b1;
    @(negedge clk);
    chk_eq("ready_start_wr", 32'(wrr1), 32'd0);
    tick(); start = 1'b0;
    chk_eq("busy_full", 32'(busy1), 32'd1);
    chk_eq("instr_full0", 32'(instr1), 32'h01);
    chk_eq("ready_run", 32'(wrr1), 32'd0);
    wait_done(1'b0, 17, "cycles_full");
    wr_valid = 1'b0;
    chk_eq("len_after_full", 32'(len1), 32'd16);
    tick();

    // clear then empty start
    clear = 1'b1; tick(); clear = 1'b0;
    chk_eq("len_clear", 32'(len1), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk_eq("done_empty", 32'(done1), 32'd1);
    chk_eq("busy_empty", 32'(busy1), 32'd0);
    tick();
    chk_eq("done_empty_end", 32'(done1), 32'd0);

    // HOLD=3: abort in step 2, then full replay
    mon1_en = 1'b0; mon3_en = 1'b1;
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 4; i++) wr(prog3[i], 1'b1);
    chk_eq("len3_h3", 32'(len3), 32'd4);
    q3.push_back(core_f(prog3[0]));
    rv3_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk_eq("h3_instr_c1", 32'(instr3), 32'(prog3[0]));
    tick(); tick(); tick();
    chk_eq("h3_instr_c4", 32'(instr3), 32'(prog3[1]));
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk_eq("abort_done", 32'(done3), 32'd1);
    chk_eq("abort_busy", 32'(busy3), 32'd0);
    chk_eq("abort_instr", 32'(instr3), 32'd0);
    tick(); tick();
    chk_eq("abort_rv_count", 32'(rv3_cnt), 32'd1);
    chk_eq("abort_q_empty", 32'(q3.size()), 32'd0);
    for (int i = 0; i < 4; i++) q3.push_back(core_f(prog3[i]));
    start = 1'b1; tick(); start = 1'b0;
    chk_eq("replay_instr0", 32'(instr3), 32'(prog3[0]));
    wait_done(1'b1, 13, "cycles_h3");
    tick();
    chk_eq("replay_q_empty", 32'(q3.size()), 32'd0);

    // reset during step 2
    q3.push_back(core_f(prog3[0]));
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0; tick();
    chk_eq("rrun_instr", 32'(instr3), 32'd0);
    chk_eq("rrun_busy", 32'(busy3), 32'd0);
    chk_eq("rrun_len", 32'(len3), 32'd0);
    chk_eq("rrun_done", 32'(done3), 32'd0);
    reset = 1'b1; tick();
    chk_eq("rrun_done2", 32'(done3), 32'd0);
    chk_eq("rrun_q3_empty", 32'(q3.size()), 32'd0);
    chk_eq("q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
